// File: rtl/plab3_mem_writemergebuffer.sv
// Single-line write-merge buffer: coalesces 32-bit word writes into one 16B line
// and drains {line addr, 128b data, 16b byte enables} to the data-array write port.

module plab3_mem_decoderwben (
    input  logic [1:0]  in_off,
    output logic [15:0] out_wben
);
    assign out_wben = 16'h000F << {in_off, 2'b00};
endmodule

module plab3_mem_writemergebuffer #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32,
    parameter int p_timeout    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [p_addr_nbits-1:0]   in_addr,
    input  logic [p_data_nbits-1:0]   in_data,
    input  logic                      flush,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [p_addr_nbits-1:0]   out_addr,
    output logic [4*p_data_nbits-1:0] out_data,
    output logic [15:0]               out_wben,
    output logic                      empty
);
    localparam int         TAG_W      = p_addr_nbits - 4;
    localparam int         LINE_W     = 4 * p_data_nbits;
    localparam logic [7:0] TIMER_LAST = 8'(p_timeout - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [15:0]       mask_q, mask_d;
    logic [7:0]        timer_q, timer_d;
    logic              out_val_q, out_val_d;
    logic              empty_q, empty_d;

    logic [TAG_W-1:0]  in_tag;
    logic [1:0]        in_off;
    logic [15:0]       in_wben;
    logic [LINE_W-1:0] merged_data;
    logic [15:0]       merged_mask;
    logic              tag_match;
    logic              fire;
    logic              unused_addr_lsb;

    assign in_tag          = in_addr[p_addr_nbits-1:4];
    assign in_off          = in_addr[3:2];
    assign unused_addr_lsb = ^in_addr[1:0];
    assign tag_match       = (in_tag == tag_q);

    plab3_mem_decoderwben u_decoder_wben (
        .in_off   (in_off),
        .out_wben (in_wben)
    );

    // Ready is a function of state, address and flush only, so it never loops back on in_val.
    always_comb begin
        in_rdy = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE:    in_rdy = 1'b1;
                MERGE:   in_rdy = tag_match & ~flush;
                default: in_rdy = 1'b0;
            endcase
        end
    end

    assign fire = in_val & in_rdy;

    always_comb begin
        merged_data = data_q;
        for (int k = 0; k < 4; k++) begin
            if (in_off == 2'(k)) begin
                merged_data[k*p_data_nbits +: p_data_nbits] = in_data;
            end
        end
        merged_mask = mask_q | in_wben;
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    tag_d   = in_tag;
                    data_d  = merged_data;
                    mask_d  = merged_mask;
                    timer_d = '0;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                // A mismatching request is left pending; it is taken from IDLE after the drain.
                if (flush || (in_val && !tag_match)) begin
                    state_d = DRAIN;
                end else if (fire) begin
                    data_d  = merged_data;
                    mask_d  = merged_mask;
                    timer_d = '0;
                    if (merged_mask == 16'hFFFF) begin
                        state_d = DRAIN;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = DRAIN;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DRAIN: begin
                if (out_rdy) begin
                    mask_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_val_d = (state_d == DRAIN);
    assign empty_d   = (state_d == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            timer_q   <= '0;
            out_val_q <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            out_val_q <= out_val_d;
            empty_q   <= empty_d;
        end
    end

    assign out_val  = out_val_q;
    assign empty    = empty_q;
    assign out_addr = {tag_q, 4'b0000};
    assign out_data = data_q;
    assign out_wben = mask_q;

endmodule

// File: tb/tb_plab3_mem_writemergebuffer.sv
// Bench for plab3_mem_writemergebuffer: table of single-word lines plus
// hand-written merge, stall, timeout and reset sequences, checked by a line scoreboard.

module tb_plab3_mem_writemergebuffer;
    localparam int P_TO = 16;

    logic         clk;
    logic         reset_n;
    logic         in_val;
    logic         in_rdy;
    logic [31:0]  in_addr;
    logic [31:0]  in_data;
    logic         flush;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_addr;
    logic [127:0] out_data;
    logic [15:0]  out_wben;
    logic         empty;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  wben;
    } line_t;

    typedef struct packed {
        logic [31:0] in_addr;
        logic [31:0] in_data;
        line_t       exp;
    } vec_t;

    line_t exp_q[$];
    line_t mon_e;
    int    n_vec   = 0;
    int    n_err   = 0;
    int    n_push  = 0;
    int    n_lines = 0;

    plab3_mem_writemergebuffer #(
        .p_addr_nbits (32),
        .p_data_nbits (32),
        .p_timeout    (P_TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .flush    (flush),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_wben (out_wben),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] byte_mask(input logic [15:0] w);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (w[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Every handshake pops the oldest expected line.
    always @(negedge clk) begin
        if (reset_n && out_val && out_rdy) begin
            n_lines++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL line_extra: got line addr %0h wben %0h with nothing expected", out_addr, out_wben);
            end else begin
                mon_e = exp_q.pop_front();
                chk("line_addr", {96'd0, out_addr}, {96'd0, mon_e.addr});
                chk("line_wben", {112'd0, out_wben}, {112'd0, mon_e.wben});
                chk("line_data", out_data & byte_mask(mon_e.wben), mon_e.data & byte_mask(mon_e.wben));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d, input logic [15:0] w);
        line_t l;
        l.addr = a;
        l.data = d;
        l.wben = w;
        exp_q.push_back(l);
        n_push++;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        bit done;
        done    = 1'b0;
        in_val  = 1'b1;
        in_addr = a;
        in_data = d;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (in_rdy) done = 1'b1;
            tick();
        end
        in_val = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL write_accept: addr %0h not accepted within 60 cycles", a);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (empty && !out_val) done = 1'b1;
            tick();
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: buffer still holding a line after 100 cycles (empty=%0b out_val=%0b)", empty, out_val);
        end
    endtask

    initial begin
        vec_t vt[4];
        int   cnt;
        bit   got;

        vt[0] = '{32'h0000_2004, 32'h0000_0011,
                  '{32'h0000_2000, 128'h00000000_00000000_00000011_00000000, 16'h00F0}};
        vt[1] = '{32'hFFFF_FFF3, 32'hDEAD_BEEF,
                  '{32'hFFFF_FFF0, 128'h00000000_00000000_00000000_DEADBEEF, 16'h000F}};
        vt[2] = '{32'h0000_0ABE, 32'h1234_5678,
                  '{32'h0000_0AB0, 128'h12345678_00000000_00000000_00000000, 16'hF000}};
        vt[3] = '{32'h8000_0009, 32'hCAFE_F00D,
                  '{32'h8000_0000, 128'h00000000_CAFEF00D_00000000_00000000, 16'h0F00}};

        reset_n = 1'b0;
        in_val  = 1'b0;
        in_addr = '0;
        in_data = '0;
        flush   = 1'b0;
        out_rdy = 1'b1;

        @(negedge clk);
        chk("rst_out_val", {127'd0, out_val}, 128'd0);
        chk("rst_empty",   {127'd0, empty},   128'd1);
        chk("rst_in_rdy",  {127'd0, in_rdy},  128'd0);
        chk("rst_wben",    {112'd0, out_wben}, 128'd0);
        chk("rst_addr",    {96'd0, out_addr}, 128'd0);
        chk("rst_data",    out_data,          128'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Four back-to-back words fill the line and drain it immediately.
        push(32'h0000_1000, 128'h000000DD_000000CC_000000BB_000000AA, 16'hFFFF);
        write(32'h0000_1000, 32'hAA);
        write(32'h0000_1004, 32'hBB);
        write(32'h0000_1008, 32'hCC);
        write(32'h0000_100C, 32'hDD);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            push(vt[i].exp.addr, vt[i].exp.data, vt[i].exp.wben);
            write(vt[i].in_addr, vt[i].in_data);
            do_flush();
            wait_idle();
        end

        // Flush with nothing held does nothing.
        flush = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("idle_flush_out_val", {127'd0, out_val}, 128'd0);
            chk("idle_flush_empty",   {127'd0, empty},   128'd1);
            tick();
        end
        flush = 1'b0;

        // Tag change stalls the new request until the old line drains.
        push(32'h0000_3000, 128'h00000000_00000000_00000000_00000001, 16'h000F);
        push(32'h0000_4000, 128'h00000000_00000000_00000000_00000002, 16'h000F);
        write(32'h0000_3000, 32'h1);
        in_val  = 1'b1;
        in_addr = 32'h0000_4000;
        in_data = 32'h2;
        @(negedge clk);
        chk("mismatch_in_rdy", {127'd0, in_rdy}, 128'd0);
        tick();
        write(32'h0000_4000, 32'h2);
        do_flush();
        wait_idle();

        // Same word written twice: the later value wins, one line.
        push(32'h0000_5000, 128'h00000000_00000009_00000000_00000000, 16'h0F00);
        write(32'h0000_5008, 32'h7);
        write(32'h0000_5008, 32'h9);
        do_flush();
        wait_idle();

        // Idle timeout, then outputs held while downstream stalls.
        out_rdy = 1'b0;
        push(32'h0000_6000, 128'h00000000_00000000_00000000_0000005A, 16'h000F);
        write(32'h0000_6000, 32'h5A);
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < P_TO + 20 && !got; k++) begin
            @(negedge clk);
            if (out_val) got = 1'b1;
            else begin
                tick();
                cnt++;
            end
        end
        chk("timeout_edges", 128'(cnt), 128'(P_TO));
        chk("drain_in_rdy", {127'd0, in_rdy}, 128'd0);
        for (int j = 0; j < 5; j++) begin
            chk("stall_out_val", {127'd0, out_val}, 128'd1);
            chk("stall_addr", {96'd0, out_addr}, {96'd0, 32'h0000_6000});
            chk("stall_wben", {112'd0, out_wben}, {112'd0, 16'h000F});
            chk("stall_word0", {96'd0, out_data[31:0]}, {96'd0, 32'h5A});
            tick();
            @(negedge clk);
        end
        tick();
        out_rdy = 1'b1;
        wait_idle();

        // Reset while draining drops the line at once.
        out_rdy = 1'b0;
        write(32'h0000_7000, 32'h33);
        do_flush();
        @(negedge clk);
        chk("pre_reset_out_val", {127'd0, out_val}, 128'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_out_val", {127'd0, out_val}, 128'd0);
        chk("mid_reset_empty",   {127'd0, empty},   128'd1);
        chk("mid_reset_in_rdy",  {127'd0, in_rdy},  128'd0);
        chk("mid_reset_wben",    {112'd0, out_wben}, 128'd0);
        chk("mid_reset_addr",    {96'd0, out_addr}, 128'd0);
        chk("mid_reset_data",    out_data,          128'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        push(32'h0000_7000, 128'h00000000_00000044_00000000_00000000, 16'h0F00);
        write(32'h0000_7008, 32'h44);
        do_flush();
        @(negedge clk);
        chk("fresh_wben", {112'd0, out_wben}, {112'd0, 16'h0F00});
        chk("fresh_data", out_data, 128'h00000000_00000044_00000000_00000000);
        tick();
        out_rdy = 1'b1;
        wait_idle();

        chk("lines_drained", 128'(n_lines), 128'(n_push));
        chk("lines_pending", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
